// File: rtl/rr_bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package rr_bus_arbiter_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned SEL_W  = 5;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr,
                                               input int unsigned n_req);
    if (32'(ptr) + 32'd1 >= n_req) return '0;
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/mux32_32x1.sv
// 32-input word multiplexer; input word k occupies D[32k+31:32k].
module MUX32_32x1 (
  input  logic [1023:0] D,
  input  logic [4:0]    S,
  output logic [31:0]   Y
);

  assign Y = D[{S, 5'b00000} +: 32];

endmodule

// File: rtl/rr_bus_arbiter_pick.sv
// Rotate-priority finder: first asserted request scanning from ptr upward, wrapping.
module rr_pick
  import rr_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_found,
  output logic [SEL_W-1:0] o_idx
);

  logic [31:0] w_req_ext;

  // Walk the scan order backwards so the earliest hit is the last assignment.
  always_comb begin
    w_req_ext = '0;
    w_req_ext[N_REQ-1:0] = i_req;
    o_found = |i_req;
    o_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_req_ext[SEL_W'((32'(i_ptr) + (N_REQ - 1 - i)) % N_REQ)])
        o_idx = SEL_W'((32'(i_ptr) + (N_REQ - 1 - i)) % N_REQ);
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing one 32-bit datapath between N_REQ requesters,
// with bounded grant tenure and a registered valid-qualified output beat.
module rr_bus_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned SEL_W    = 5,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N_REQ-1:0]    REQ,
  input  logic [N_REQ*32-1:0] DATA_IN,
  output logic [N_REQ-1:0]    GNT,
  output logic [SEL_W-1:0]    SEL,
  output logic [31:0]         Y,
  output logic                Y_VALID
);

  import rr_bus_arbiter_pkg::*;

  arb_state_t       r_state, w_next_state;
  logic [N_REQ-1:0] r_gnt;
  logic [SEL_W-1:0] r_sel, r_ptr;
  logic [7:0]       r_hold;
  logic [31:0]      r_y;
  logic             r_y_valid;

  logic             w_found;
  logic [SEL_W-1:0] w_pick_idx;
  logic [1023:0]    w_mux_in;
  logic [31:0]      w_mux_y;
  logic [31:0]      w_req_ext;
  logic             w_req_k, w_beat, w_expire, w_release;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req  (REQ),
    .i_ptr  (r_ptr),
    .o_found(w_found),
    .o_idx  (w_pick_idx)
  );

  always_comb begin
    w_mux_in = '0;
    w_mux_in[N_REQ*32-1:0] = DATA_IN;
  end

  MUX32_32x1 u_mux (
    .D(w_mux_in),
    .S(r_sel),
    .Y(w_mux_y)
  );

  always_comb begin
    w_req_ext = '0;
    w_req_ext[N_REQ-1:0] = REQ;
    w_req_k      = w_req_ext[r_sel];
    w_beat       = 1'b0;
    w_expire     = 1'b0;
    w_release    = 1'b0;
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) w_next_state = ARB_GRANT;
      end
      ARB_GRANT: begin
        w_beat    = w_req_k;
        w_expire  = w_req_k && (r_hold + 8'd1 == 8'(MAX_HOLD));
        w_release = !w_req_k || w_expire;
        if (w_release) w_next_state = ARB_IDLE;
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= '0;
      r_sel     <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_y_valid <= w_beat;
      if (w_beat) begin
        r_y    <= w_mux_y;
        r_hold <= r_hold + 8'd1;
      end
      if (r_state == ARB_IDLE && w_found) begin
        r_gnt  <= N_REQ'(1) << w_pick_idx;
        r_sel  <= w_pick_idx;
        r_hold <= '0;
      end
      // SEL is left alone on release so the mux select stays stable.
      if (w_release) begin
        r_gnt <= '0;
        r_ptr <= rr_next(r_sel, N_REQ);
      end
    end
  end

  assign GNT     = r_gnt;
  assign SEL     = r_sel;
  assign Y       = r_y;
  assign Y_VALID = r_y_valid;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboard bench for rr_bus_arbiter against a transaction-level round-robin model.
module tb_rr_bus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned MH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  req;
  logic [N*32-1:0] data;
  logic [N-1:0]  gnt;
  logic [4:0]    sel;
  logic [31:0]   y;
  logic          yv;

  logic          rst_b;
  logic [31:0]   req_b;
  logic [1023:0] data_b;
  logic [31:0]   gnt_b;
  logic [4:0]    sel_b;
  logic [31:0]   y_b;
  logic          yv_b;

  rr_bus_arbiter #(.N_REQ(N), .SEL_W(5), .MAX_HOLD(MH)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .DATA_IN(data),
    .GNT(gnt), .SEL(sel), .Y(y), .Y_VALID(yv)
  );

  rr_bus_arbiter #(.N_REQ(32), .SEL_W(5), .MAX_HOLD(4)) dut_b (
    .CLK(clk), .RST(rst_b), .REQ(req_b), .DATA_IN(data_b),
    .GNT(gnt_b), .SEL(sel_b), .Y(y_b), .Y_VALID(yv_b)
  );

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [4:0]   sel;
    logic [31:0]  y;
    logic         yv;
  } stat_t;

  typedef struct packed {
    logic [31:0] y;
    logic [4:0]  sel;
  } beat_t;

  stat_t stat_q[$];
  beat_t beat_q[$];
  int unsigned checks = 0;
  int unsigned passes = 0;

  // Model: who owns the bus, where the scan starts, beats spent this tenure.
  int          owner = -1;
  int          ptr = 0;
  int          held = 0;
  int          last_sel = 0;
  logic [31:0] last_y = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_step();
    stat_t s;
    beat_t b;
    logic  beat;
    int    k;
    beat = 1'b0;
    if (rst) begin
      owner = -1; ptr = 0; held = 0; last_sel = 0; last_y = '0;
    end else if (owner < 0) begin
      for (int off = 0; off < int'(N); off++) begin
        k = (ptr + off) % int'(N);
        if (owner < 0 && req[k]) begin
          owner = k; held = 0; last_sel = k;
        end
      end
    end else begin
      if (req[owner]) begin
        beat   = 1'b1;
        last_y = data[owner*32 +: 32];
        b.y    = last_y;
        b.sel  = 5'(owner);
        beat_q.push_back(b);
        held++;
      end
      if (!req[owner] || held == int'(MH)) begin
        ptr   = (owner + 1) % int'(N);
        owner = -1;
      end
    end
    s.gnt = (owner < 0) ? '0 : (N'(1) << owner);
    s.sel = 5'(last_sel);
    s.y   = last_y;
    s.yv  = beat;
    stat_q.push_back(s);
  endtask

  task automatic drive(input logic r, input logic [N-1:0] q, input logic [N*32-1:0] d);
    @(negedge clk);
    rst = r; req = q; data = d;
    model_step();
  endtask

  function automatic logic [N*32-1:0] rdata();
    logic [N*32-1:0] v;
    for (int i = 0; i < int'(N); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Monitor: compare every cycle's status, and each presented beat in order.
  initial begin
    stat_t e;
    beat_t eb;
    forever begin
      @(posedge clk); #1;
      if (stat_q.size() > 0) begin
        e = stat_q.pop_front();
        chk("gnt", 64'(gnt), 64'(e.gnt));
        chk("sel", 64'(sel), 64'(e.sel));
        chk("y", 64'(y), 64'(e.y));
        chk("y_valid", 64'(yv), 64'(e.yv));
        chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
        chk("sel_range", 64'(sel < 5'(N)), 64'd1);
      end
      if (yv === 1'b1) begin
        if (beat_q.size() == 0) begin
          checks++;
          $display("FAIL beat_unexpected: got Y=%h sel=%0d expected no beat", y, sel);
        end else begin
          eb = beat_q.pop_front();
          chk("beat_y", 64'(y), 64'(eb.y));
          chk("beat_sel", 64'(sel), 64'(eb.sel));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*32-1:0] d;
    logic [N-1:0]    rq;
    rst = 1'b1; req = '0; data = '0;
    rst_b = 1'b1; req_b = '0; data_b = '0;

    repeat (2) drive(1'b1, '0, '0);

    d = rdata();
    d[2*32 +: 32] = 32'hCAFEF00D;
    repeat (4) drive(1'b0, 4'b0100, d);
    repeat (2) drive(1'b0, 4'b0000, rdata());

    repeat (5) drive(1'b0, 4'b0011, rdata());
    repeat (2) drive(1'b0, 4'b0000, rdata());

    repeat (40) drive(1'b0, 4'b1111, rdata());
    repeat (2) drive(1'b0, 4'b0000, rdata());
    repeat (30) drive(1'b0, 4'b0010, rdata());
    repeat (2) drive(1'b0, 4'b0000, rdata());

    repeat (4) drive(1'b0, 4'b1000, rdata());
    drive(1'b1, 4'b1000, rdata());
    repeat (4) drive(1'b0, 4'b1010, rdata());

    rq = '0;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      drive($urandom_range(0, 49) == 0, rq, rdata());
    end
    repeat (3) drive(1'b0, 4'b0000, '0);
    repeat (2) @(posedge clk);
    #2;
    chk("stat_q_drained", 64'(stat_q.size()), 64'd0);
    chk("beat_q_drained", 64'(beat_q.size()), 64'd0);

    @(negedge clk);
    rst_b = 1'b0;
    req_b = 32'h8000_0000;
    for (int i = 0; i < 32; i++) data_b[i*32 +: 32] = $urandom;
    data_b[31*32 +: 32] = 32'h12345678;
    @(posedge clk); #1;
    chk("b_gnt", 64'(gnt_b), 64'h8000_0000);
    chk("b_sel", 64'(sel_b), 64'd31);
    chk("b_valid_grant", 64'(yv_b), 64'd0);
    @(posedge clk); #1;
    chk("b_y", 64'(y_b), 64'h12345678);
    chk("b_valid_beat", 64'(yv_b), 64'd1);
    @(negedge clk);
    req_b = '0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit datapath between N_REQ requesters.
- Grants one requester at a time.
- Drives the select of the team's MUX32_32x1 word mux.
- Registers the selected word as a valid-qualified output beat.
- Bounds grant tenure with a hold counter so no requester can starve the others.
- Sits between producer blocks (e.g. register-file read clients, debug/DMA ports) and a shared 32-bit consumer bus.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..32.
- SEL_W, 5, select width; fixed at 5 to match the 32-input word mux.
- MAX_HOLD, 8, maximum beats per grant; legal range 1..255.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  N_REQ  per-requester request; held high while the requester has beats to send.
- DATA_IN  input  N_REQ*32  flattened requester words; requester k drives bits [32k+31:32k].
- GNT  output  N_REQ  one-hot grant, registered.
- SEL  output  SEL_W  index of the granted requester, registered; drives the mux select.
- Y  output  32  registered output word.
- Y_VALID  output  1  Y carries a beat this cycle.

Behaviour:
- Reset (RST high at an edge, priority over everything) sets:
  - state=IDLE, GNT=0, SEL=0, Y=0, Y_VALID=0.
  - rr pointer ptr=0, hold_cnt=0.
- States: IDLE, GRANT.
- IDLE:
  - If REQ==0, stay in IDLE. GNT=0, Y_VALID=0 next cycle.
  - Else pick the first asserted REQ[k] scanning k=ptr, ptr+1, ..., wrapping modulo N_REQ.
  - Next cycle: GNT=onehot(k), SEL=k, hold_cnt=0, state=GRANT.
- GRANT, granted requester k, at each edge:
  - Beat: REQ[k]=1. Y<=DATA_IN[k] (via the mux at select SEL), Y_VALID<=1, hold_cnt<=hold_cnt+1.
  - Drop: REQ[k]=0. No beat, Y_VALID<=0. Release.
  - Expiry: a beat where hold_cnt+1==MAX_HOLD. The beat is transferred, then release.
  - Release means GNT<=0, ptr<=(k+1) mod N_REQ, state<=IDLE. SEL keeps its value.
- Release always costs exactly one IDLE bubble cycle before the next GNT. This holds even if the same requester is the only one pending; it regains the grant after the bubble.
- Latency:
  - REQ sampled at edge t0 in IDLE -> GNT high after t0.
  - First beat captured at t1 -> Y_VALID high after t1.
  - One beat per cycle thereafter.
- REQ of non-granted requesters is ignored during GRANT and never preempts.
- Y holds its last value when Y_VALID=0.
- Bits of GNT and REQ at indices >= N_REQ do not exist. Mux inputs 31..N_REQ are tied to 0.
- Invariants:
  - GNT is one-hot or zero.
  - SEL always < N_REQ.
  - Y_VALID never high in the cycle after RST.
- Reset mid-grant: GNT, Y_VALID and hold_cnt clear at that edge. ptr returns to 0; no partial-tenure memory survives.

Decomposition:
- Shared package:
  - State encoding constants ARB_IDLE=1'b0, ARB_GRANT=1'b1.
  - WORD_W=32, SEL_W=5.
  - Function rr_next(ptr, N_REQ) for the modulo increment.
- Sub-module rr_pick: combinational rotate-priority finder.
  - Inputs: REQ vector, ptr.
  - Outputs: found flag, 5-bit index.
- Top instantiates rr_pick, the state/hold/pointer registers, MUX32_32x1 on SEL, and the 32-bit Y register.

Test Plan:
- Reset then REQ=4'b0100, DATA_IN[2]=0xCAFEF00D for 3 cycles, then drop -> GNT=0100 one cycle after REQ; Y=0xCAFEF00D with Y_VALID high for exactly 3 cycles; then GNT=0 and ptr=3.
- REQ=4'b1111 held continuously, MAX_HOLD=8 -> grants in order 0,1,2,3,0. Each grant gives 8 Y_VALID beats followed by one bubble cycle with GNT=0.
- Only REQ[1] held continuously -> 8 beats, 1 bubble, GNT=0010 again, repeating. Y_VALID duty is 8 of 9 cycles.
- ptr=3 after releasing requester 2, then REQ=4'b0011 -> requester 0 granted (wrap-around), not 1.
- RST asserted on the 4th beat of a grant to requester 3 -> GNT=0 and Y_VALID=0 at that edge. Then REQ=4'b1010 -> requester 1 granted (ptr=0 scan).
- N_REQ=32, REQ bit 31 only, DATA_IN[31]=0x12345678 -> SEL=31; Y=0x12345678 after one beat.
